// File: rtl/booth_divider_module.sv
// Sequential signed 8-bit divider: restoring shift-subtract on magnitudes, one quotient
// bit per clock, followed by sign correction. Start_Sig/Done_Sig handshake with a 4-bit step counter.
module booth_divider_module (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Start_Sig,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic       Done_Sig,
    output logic [7:0] Quotient,
    output logic [7:0] Remainder,
    output logic       Div_Zero,
    output logic [8:0] SQ_r,
    output logic [7:0] SQ_q
);

    // state    | meaning
    // PH_LOAD  | step 0: latch operand magnitudes, sign and zero flags
    // PH_ITER  | steps 1-8: one restoring shift-subtract per clock
    // PH_OUT   | step 9: sign-correct and register results, pulse Done_Sig
    // PH_WRAP  | step 10: drop Done_Sig, return to step 0
    typedef enum logic [1:0] {PH_LOAD, PH_ITER, PH_OUT, PH_WRAP} phase_t;

    phase_t     w_phase;

    logic [3:0] r_i,    w_i_nxt;
    logic [8:0] r_r,    w_r_nxt;
    logic [7:0] r_q,    w_q_nxt;
    logic [7:0] r_d,    w_d_nxt;
    logic       r_sq,   w_sq_nxt;
    logic       r_sr,   w_sr_nxt;
    logic       r_z,    w_z_nxt;
    logic       r_done, w_done_nxt;
    logic [7:0] r_quot, w_quot_nxt;
    logic [7:0] r_rem,  w_rem_nxt;
    logic       r_dz,   w_dz_nxt;

    logic [7:0] w_a_mag;
    logic [7:0] w_b_mag;
    logic [8:0] w_shifted;
    logic [8:0] w_trial;
    logic [7:0] w_neg_q;
    logic [7:0] w_neg_r;

    // Two's-complement negation maps -128 onto 8'h80, which is its unsigned magnitude.
    assign w_a_mag   = A[7] ? (~A + 8'd1) : A;
    assign w_b_mag   = B[7] ? (~B + 8'd1) : B;
    assign w_shifted = {r_r[7:0], r_q[7]};
    assign w_trial   = w_shifted - {1'b0, r_d};
    assign w_neg_q   = ~r_q + 8'd1;
    assign w_neg_r   = ~r_r[7:0] + 8'd1;

    always_comb begin
        if (r_i == 4'd0)
            w_phase = PH_LOAD;
        else if (r_i <= 4'd8)
            w_phase = PH_ITER;
        else if (r_i == 4'd9)
            w_phase = PH_OUT;
        else
            w_phase = PH_WRAP;
    end

    always_comb begin
        w_i_nxt    = r_i;
        w_r_nxt    = r_r;
        w_q_nxt    = r_q;
        w_d_nxt    = r_d;
        w_sq_nxt   = r_sq;
        w_sr_nxt   = r_sr;
        w_z_nxt    = r_z;
        w_done_nxt = r_done;
        w_quot_nxt = r_quot;
        w_rem_nxt  = r_rem;
        w_dz_nxt   = r_dz;
        if (Start_Sig) begin
            case (w_phase)
                PH_LOAD: begin
                    w_q_nxt  = w_a_mag;
                    w_d_nxt  = w_b_mag;
                    w_sq_nxt = A[7] ^ B[7];
                    w_sr_nxt = A[7];
                    w_z_nxt  = (B == 8'd0);
                    w_r_nxt  = 9'd0;
                    w_i_nxt  = 4'd1;
                end
                PH_ITER: begin
                    if (!w_trial[8]) begin
                        w_r_nxt = w_trial;
                        w_q_nxt = {r_q[6:0], 1'b1};
                    end else begin
                        w_r_nxt = w_shifted;
                        w_q_nxt = {r_q[6:0], 1'b0};
                    end
                    w_i_nxt = r_i + 4'd1;
                end
                PH_OUT: begin
                    // A zero divisor leaves r = |A|, so the sign fix-up already returns A itself.
                    w_quot_nxt = r_z ? 8'hFF : (r_sq ? w_neg_q : r_q);
                    w_rem_nxt  = r_sr ? w_neg_r : r_r[7:0];
                    w_dz_nxt   = r_z;
                    w_done_nxt = 1'b1;
                    w_i_nxt    = 4'd10;
                end
                default: begin
                    w_done_nxt = 1'b0;
                    w_i_nxt    = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_i    <= 4'd0;
            r_r    <= 9'd0;
            r_q    <= 8'd0;
            r_d    <= 8'd0;
            r_sq   <= 1'b0;
            r_sr   <= 1'b0;
            r_z    <= 1'b0;
            r_done <= 1'b0;
            r_quot <= 8'd0;
            r_rem  <= 8'd0;
            r_dz   <= 1'b0;
        end else begin
            r_i    <= w_i_nxt;
            r_r    <= w_r_nxt;
            r_q    <= w_q_nxt;
            r_d    <= w_d_nxt;
            r_sq   <= w_sq_nxt;
            r_sr   <= w_sr_nxt;
            r_z    <= w_z_nxt;
            r_done <= w_done_nxt;
            r_quot <= w_quot_nxt;
            r_rem  <= w_rem_nxt;
            r_dz   <= w_dz_nxt;
        end
    end

    assign Done_Sig  = r_done;
    assign Quotient  = r_quot;
    assign Remainder = r_rem;
    assign Div_Zero  = r_dz;
    assign SQ_r      = r_r;
    assign SQ_q      = r_q;

endmodule

// File: tb/tb_booth_divider_module.sv
// Bench for booth_divider_module: directed cases from the plan plus a randomized sweep
// against an integer-arithmetic reference model.
module tb_booth_divider_module;

    logic       CLK;
    logic       RSTn;
    logic       Start_Sig;
    logic [7:0] A;
    logic [7:0] B;
    logic       Done_Sig;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Div_Zero;
    logic [8:0] SQ_r;
    logic [7:0] SQ_q;

    int n_tests;
    int n_fail;

    booth_divider_module dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .Start_Sig (Start_Sig),
        .A         (A),
        .B         (B),
        .Done_Sig  (Done_Sig),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Div_Zero  (Div_Zero),
        .SQ_r      (SQ_r),
        .SQ_q      (SQ_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: signed integer division truncates toward zero, % takes the dividend's sign.
    task automatic ref_div(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] q, output logic [7:0] r, output logic dz);
        int sa;
        int sb;
        int iq;
        int ir;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sb == 0) begin
            q  = 8'hFF;
            r  = a;
            dz = 1'b1;
        end else begin
            iq = sa / sb;
            ir = sa % sb;
            q  = iq[7:0];
            r  = ir[7:0];
            dz = 1'b0;
        end
    endtask

    // Runs one operation from step 0; optionally drops Start_Sig for pause_len cycles after
    // edge pause_after and scrambles A/B meanwhile. Returns the edge number at which Done_Sig is seen.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input int pause_after, input int pause_len, output int lat);
        int  e;
        bit  seen;
        A         = a;
        B         = b;
        Start_Sig = 1'b1;
        e         = 0;
        seen      = 1'b0;
        lat       = 0;
        while (!seen && e < 40) begin
            @(posedge CLK);
            #1;
            e++;
            if (Done_Sig) begin
                seen = 1'b1;
                lat  = e;
            end else if (e == pause_after && pause_len > 0) begin
                Start_Sig = 1'b0;
                A         = 8'($urandom);
                B         = 8'($urandom);
                repeat (pause_len) begin
                    @(posedge CLK);
                    #1;
                    e++;
                    check({tag, "_done_in_pause"}, 16'(Done_Sig), 16'd0);
                end
                Start_Sig = 1'b1;
            end
        end
        if (!seen)
            check({tag, "_timeout"}, 16'(e), 16'd0);
        @(posedge CLK);
        #1;
        check({tag, "_done_one_cycle"}, 16'(Done_Sig), 16'd0);
        Start_Sig = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] eq, input logic [7:0] er, input logic edz,
                            input int pause_after, input int pause_len);
        int lat;
        run_div(tag, a, b, pause_after, pause_len, lat);
        check({tag, "_lat"}, 16'(lat), 16'(10 + pause_len));
        check({tag, "_q"},   16'(Quotient),  16'(eq));
        check({tag, "_r"},   16'(Remainder), 16'(er));
        check({tag, "_dz"},  16'(Div_Zero),  16'(edz));
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] mq;
        logic [7:0] mr;
        logic       mdz;
        int         lat;
        int         p_after;
        int         p_len;

        n_tests   = 0;
        n_fail    = 0;
        RSTn      = 1'b0;
        Start_Sig = 1'b0;
        A         = 8'd0;
        B         = 8'd0;
        #12;
        check("rst_done", 16'(Done_Sig),  16'd0);
        check("rst_q",    16'(Quotient),  16'd0);
        check("rst_r",    16'(Remainder), 16'd0);
        check("rst_dz",   16'(Div_Zero),  16'd0);
        check("rst_sqr",  16'(SQ_r),      16'd0);
        check("rst_sqq",  16'(SQ_q),      16'd0);
        @(negedge CLK);
        RSTn = 1'b1;

        directed("d100_7",    8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 0, 0);
        directed("dm100_7",   8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 0, 0);
        directed("d100_m7",   8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 0, 0);
        directed("dm128_m1",  8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 0, 0);
        directed("d5_9",      8'h05, 8'h09, 8'h00, 8'h05, 1'b0, 0, 0);
        directed("d2a_0",     8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b1, 0, 0);
        directed("d9_3",      8'h09, 8'h03, 8'h03, 8'h00, 1'b0, 0, 0);
        directed("dm128_0",   8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, 0, 0);
        directed("dm7_m128",  8'hF9, 8'h80, 8'h00, 8'hF9, 1'b0, 0, 0);
        directed("dpause",    8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 4, 3);

        // Abort mid-operation: outputs return to reset values and no Done_Sig follows.
        A         = 8'h64;
        B         = 8'h07;
        Start_Sig = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        RSTn = 1'b0;
        #1;
        check("abort_q",   16'(Quotient),  16'd0);
        check("abort_r",   16'(Remainder), 16'd0);
        check("abort_dz",  16'(Div_Zero),  16'd0);
        check("abort_sqr", 16'(SQ_r),      16'd0);
        check("abort_sqq", 16'(SQ_q),      16'd0);
        repeat (8) begin
            @(posedge CLK);
            #1;
            check("abort_done", 16'(Done_Sig), 16'd0);
        end
        Start_Sig = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        directed("d127_10", 8'h7F, 8'h0A, 8'h0C, 8'h07, 1'b0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                p_after = $urandom_range(1, 9);
                p_len   = $urandom_range(1, 3);
            end else begin
                p_after = 0;
                p_len   = 0;
            end
            ref_div(ra, rb, mq, mr, mdz);
            run_div("rnd", ra, rb, p_after, p_len, lat);
            check("rnd_lat", 16'(lat),       16'(10 + p_len));
            check("rnd_q",   16'(Quotient),  16'(mq));
            check("rnd_r",   16'(Remainder), 16'(mr));
            check("rnd_dz",  16'(Div_Zero),  16'(mdz));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
